// File: rtl/serial_digit_adder.sv
// Digit-serial adder/subtractor: WIDTH-bit operands processed DIGIT bits
// per clock, LSB digit first, with valid/ready handshakes on both sides.
module serial_digit_adder #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf
);

  localparam int CYCLES = WIDTH / DIGIT;
  localparam int CW = (CYCLES > 1) ? $clog2(CYCLES) : 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_res;
  logic [WIDTH-1:0] r_s;
  logic [CW-1:0]    r_cnt;
  logic             r_c;
  logic             r_cout;
  logic             r_ovf;

  logic             w_accept;
  logic             w_last;
  logic [DIGIT:0]   w_dsum;
  logic             w_msb_cin;
  logic [WIDTH-1:0] w_res_next;

  assign in_ready  = (r_state == IDLE) && !rst;
  assign out_valid = (r_state == DONE);
  assign s         = r_s;
  assign cout      = r_cout;
  assign ovf       = r_ovf;

  assign w_accept = in_valid && in_ready;
  assign w_last   = (r_state == RUN) && (r_cnt == CW'(CYCLES - 1));

  assign w_dsum = {1'b0, r_a[DIGIT-1:0]}
                + {1'b0, r_b[DIGIT-1:0]}
                + {{DIGIT{1'b0}}, r_c};

  // Carry into the digit's top bit; on the last digit that bit is the MSB.
  assign w_msb_cin = r_a[DIGIT-1] ^ r_b[DIGIT-1] ^ w_dsum[DIGIT-1];

  assign w_res_next = (WIDTH'(w_dsum[DIGIT-1:0]) << (WIDTH - DIGIT))
                    | (r_res >> DIGIT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE: if (w_accept) w_next = RUN;
      RUN:  if (w_last) w_next = DONE;
      DONE: if (out_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a    <= '0;
      r_b    <= '0;
      r_c    <= 1'b0;
      r_cnt  <= '0;
      r_res  <= '0;
      r_s    <= '0;
      r_cout <= 1'b0;
      r_ovf  <= 1'b0;
    end else if (w_accept) begin
      r_a   <= a;
      r_b   <= sub ? ~b : b;
      r_c   <= sub ? ~cin : cin;
      r_cnt <= '0;
      r_res <= '0;
    end else if (r_state == RUN) begin
      r_a   <= r_a >> DIGIT;
      r_b   <= r_b >> DIGIT;
      r_c   <= w_dsum[DIGIT];
      r_res <= w_res_next;
      r_cnt <= r_cnt + 1'b1;
      if (w_last) begin
        r_s    <= w_res_next;
        r_cout <= w_dsum[DIGIT];
        r_ovf  <= w_msb_cin ^ w_dsum[DIGIT];
      end
    end
  end

endmodule

// File: tb/tb_serial_digit_adder.sv
// Bench for serial_digit_adder: vector table, hand sequences and random
// operands on DIGIT = 4, 1, 8, 16 instances against an arithmetic model.
module tb_serial_digit_adder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  in_valid = '0;
  logic [3:0]  out_ready = '0;
  logic [15:0] a = '0;
  logic [15:0] b = '0;
  logic        cin = 1'b0;
  logic        sub = 1'b0;

  logic [3:0]  in_ready;
  logic [3:0]  out_valid;
  logic [3:0]  cout_o;
  logic [3:0]  ovf_o;
  logic [15:0] s_o [4];

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  serial_digit_adder #(.WIDTH(16), .DIGIT(4)) u_d4 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .a(a), .b(b), .cin(cin), .sub(sub),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]),
    .s(s_o[0]), .cout(cout_o[0]), .ovf(ovf_o[0])
  );

  serial_digit_adder #(.WIDTH(16), .DIGIT(1)) u_d1 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .a(a), .b(b), .cin(cin), .sub(sub),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]),
    .s(s_o[1]), .cout(cout_o[1]), .ovf(ovf_o[1])
  );

  serial_digit_adder #(.WIDTH(16), .DIGIT(8)) u_d8 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid[2]), .in_ready(in_ready[2]),
    .a(a), .b(b), .cin(cin), .sub(sub),
    .out_valid(out_valid[2]), .out_ready(out_ready[2]),
    .s(s_o[2]), .cout(cout_o[2]), .ovf(ovf_o[2])
  );

  serial_digit_adder #(.WIDTH(16), .DIGIT(16)) u_d16 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid[3]), .in_ready(in_ready[3]),
    .a(a), .b(b), .cin(cin), .sub(sub),
    .out_valid(out_valid[3]), .out_ready(out_ready[3]),
    .s(s_o[3]), .cout(cout_o[3]), .ovf(ovf_o[3])
  );

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        sub;
    logic [15:0] s;
    logic        cout;
    logic        ovf;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference from plain signed/unsigned arithmetic
  task automatic model(input logic [15:0] ma, input logic [15:0] mb,
                       input logic mc, input logic ms,
                       output logic [15:0] rs, output logic rc,
                       output logic ro);
    int ua, ub, sa, sb, ur, sr;
    ua = int'(ma);
    ub = int'(mb);
    sa = int'($signed(ma));
    sb = int'($signed(mb));
    if (!ms) begin
      ur = ua + ub + int'(mc);
      sr = sa + sb + int'(mc);
      rc = (ur >= 65536);
    end else begin
      ur = ua - ub - int'(mc);
      sr = sa - sb - int'(mc);
      rc = (ua >= ub + int'(mc));
    end
    rs = 16'(ur);
    ro = (sr > 32767) || (sr < -32768);
  endtask

  task automatic run_op(input int k, input logic [15:0] ia,
                        input logic [15:0] ib, input logic ic,
                        input logic isb, input bit rel,
                        output logic [15:0] os, output logic oc,
                        output logic oo, output int lat);
    int w;
    @(negedge clk);
    w = 0;
    while (!in_ready[k] && w < 100) begin
      @(negedge clk);
      w++;
    end
    if (w >= 100) begin
      failures++;
      $display("FAIL in_ready_wait dut%0d: got 0 expected 1", k);
    end
    a = ia;
    b = ib;
    cin = ic;
    sub = isb;
    in_valid[k] = 1'b1;
    @(posedge clk);
    #1;
    in_valid[k] = 1'b0;
    lat = 0;
    while (!out_valid[k] && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
    if (lat >= 100) begin
      failures++;
      $display("FAIL out_valid_wait dut%0d: got 0 expected 1", k);
    end
    os = s_o[k];
    oc = cout_o[k];
    oo = ovf_o[k];
    if (rel) begin
      @(negedge clk);
      out_ready[k] = 1'b1;
      @(posedge clk);
      #1;
      out_ready[k] = 1'b0;
    end
  endtask

  task automatic push(input logic [15:0] va, input logic [15:0] vb,
                      input logic vc, input logic vs, input logic [15:0] es,
                      input logic ec, input logic eo);
    vec_t v;
    v.a = va; v.b = vb; v.cin = vc; v.sub = vs;
    v.s = es; v.cout = ec; v.ovf = eo;
    vecs.push_back(v);
  endtask

  initial begin
    logic [15:0] rs, es;
    logic rc, ro, ec, eo;
    logic [15:0] hold_s;
    int lat;
    int lats[4];
    lats[0] = 4; lats[1] = 16; lats[2] = 2; lats[3] = 1;

    push(16'h1234, 16'h4321, 0, 0, 16'h5555, 0, 0);
    push(16'hFFFF, 16'h0001, 0, 0, 16'h0000, 1, 0);
    push(16'h7FFF, 16'h0001, 0, 0, 16'h8000, 0, 1);
    push(16'h0005, 16'h0007, 0, 1, 16'hFFFE, 0, 0);
    push(16'h8000, 16'h0001, 0, 1, 16'h7FFF, 1, 1);
    push(16'h0010, 16'h0001, 1, 1, 16'h000E, 1, 0);
    push(16'h0000, 16'h0000, 1, 0, 16'h0001, 0, 0);
    push(16'hFFFF, 16'hFFFF, 1, 0, 16'hFFFF, 1, 0);
    push(16'h8000, 16'h8000, 0, 0, 16'h0000, 1, 1);
    push(16'h0000, 16'h0000, 1, 1, 16'hFFFF, 0, 0);

    // Reset state
    #2;
    chk("rst_in_ready", in_ready, 4'h0);
    chk("rst_out_valid", out_valid, 4'h0);
    chk("rst_s", s_o[0], 16'h0);
    chk("rst_cout_ovf", {cout_o[0], ovf_o[0]}, 2'b00);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", in_ready, 4'hF);

    // Vector table on every instance
    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < vecs.size(); i++) begin
        run_op(k, vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub, 1'b1,
               rs, rc, ro, lat);
        chk($sformatf("vec%0d_d%0d_s", i, k), rs, vecs[i].s);
        chk($sformatf("vec%0d_d%0d_cout", i, k), rc, vecs[i].cout);
        chk($sformatf("vec%0d_d%0d_ovf", i, k), ro, vecs[i].ovf);
        chk($sformatf("vec%0d_d%0d_lat", i, k), lat, lats[k]);
      end
    end

    // Backpressure in DONE
    run_op(0, 16'h1234, 16'h4321, 0, 0, 1'b0, rs, rc, ro, lat);
    hold_s = rs;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      in_valid[0] = i[0];
      a = 16'($urandom);
      b = 16'($urandom);
      @(posedge clk);
      #1;
      chk("bp_s", s_o[0], hold_s);
      chk("bp_flags", {cout_o[0], ovf_o[0]}, {rc, ro});
      chk("bp_valid", out_valid[0], 1'b1);
      chk("bp_in_ready", in_ready[0], 1'b0);
    end
    @(negedge clk);
    in_valid[0] = 1'b0;
    out_ready[0] = 1'b1;
    @(posedge clk);
    #1;
    out_ready[0] = 1'b0;
    chk("bp_release_valid", out_valid[0], 1'b0);
    chk("bp_release_ready", in_ready[0], 1'b1);

    // Reset two cycles into RUN
    @(negedge clk);
    a = 16'hFFFF; b = 16'h0001; cin = 1'b1; sub = 1'b0;
    in_valid[0] = 1'b1;
    @(posedge clk);
    #1;
    in_valid[0] = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", out_valid[0], 1'b0);
    chk("mid_rst_s", s_o[0], 16'h0);
    chk("mid_rst_in_ready", in_ready[0], 1'b0);
    @(negedge clk);
    rst = 1'b0;
    run_op(0, 16'h00FF, 16'h0001, 0, 0, 1'b1, rs, rc, ro, lat);
    chk("after_rst_s", rs, 16'h0100);
    chk("after_rst_flags", {rc, ro}, 2'b00);
    chk("after_rst_lat", lat, 4);

    // Random operands against the model
    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < 25; i++) begin
        logic [15:0] ra, rb;
        logic rcin, rsub;
        ra = 16'($urandom);
        rb = 16'($urandom);
        rcin = 1'($urandom);
        rsub = 1'($urandom);
        model(ra, rb, rcin, rsub, es, ec, eo);
        run_op(k, ra, rb, rcin, rsub, 1'b1, rs, rc, ro, lat);
        chk($sformatf("rnd_d%0d_s", k), rs, es);
        chk($sformatf("rnd_d%0d_cout", k), rc, ec);
        chk($sformatf("rnd_d%0d_ovf", k), ro, eo);
        chk($sformatf("rnd_d%0d_lat", k), lat, lats[k]);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/serial_digit_adder.md
Name: serial_digit_adder

Overview:
- Parametrised, multi-cycle successor to the single-bit half-adder cell: adds or subtracts two WIDTH-bit operands DIGIT bits per clock, LSB digit first.
- Replaces a full-width ripple array with a small reusable digit slice, which keeps the scan-insertable area small.
- Sits between operand producers and result consumers, with valid/ready handshakes on both sides.

Parameters:
- WIDTH, 16, operand and result width in bits; must be a multiple of DIGIT.
- DIGIT, 4, bits processed per clock; 1 <= DIGIT <= WIDTH.
- CYCLES (localparam), WIDTH/DIGIT, clocks spent in RUN.

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- rst  input  1  reset, asynchronous and active-high.
- in_valid  input  1  operand set presented.
- in_ready  output  1  block can accept operands.
- a  input  WIDTH  first operand.
- b  input  WIDTH  second operand.
- cin  input  1  carry-in (add) / borrow-in (sub).
- sub  input  1  0: s = a + b + cin; 1: s = a - b - cin.
- out_valid  output  1  result available.
- out_ready  input  1  consumer accepts result.
- s  output  WIDTH  sum/difference, modulo 2^WIDTH.
- cout  output  1  raw carry out of MSB; for sub, borrow = ~cout.
- ovf  output  1  two's-complement overflow = carry into MSB XOR carry out of MSB.

Behaviour:
- States: IDLE, RUN, DONE. Reset forces IDLE, counter = 0, operand/carry/result registers = 0, out_valid = 0, s = 0, cout = 0, ovf = 0.
- in_ready = (state == IDLE) && !rst, combinational. It is 0 in RUN and DONE, so in_valid is ignored there.
- Accept:
  - Occurs when in_valid && in_ready at a rising edge.
  - Latch a, plus (sub ? ~b : b).
  - Latch carry = sub ? ~cin : cin.
  - Counter = 0; go to RUN.
- RUN, each cycle:
  - Add the low DIGIT bits of both operand registers plus carry.
  - Shift the DIGIT-bit sum into the result register from the MSB end.
  - Shift the operand registers right by DIGIT.
  - Register the new carry.
  - On the last digit (counter == CYCLES-1), also capture the carry into the MSB for ovf.
- After CYCLES RUN cycles, go to DONE. s/cout/ovf are loaded on the same edge that sets out_valid = 1.
- Latency: accept edge at cycle k gives out_valid = 1 after edge k+CYCLES. With DIGIT == WIDTH, the result appears one edge after accept.
- DONE:
  - out_valid = 1; s, cout and ovf are held stable while out_ready = 0, with no limit on hold time.
  - On out_valid && out_ready, go to IDLE; out_valid = 0 and in_ready = 1 after that edge.
  - No same-cycle re-accept.
- Output validity: s/cout/ovf are defined only while out_valid = 1. During RUN they hold their previous values.
- Arithmetic:
  - Unsigned modulo 2^WIDTH; cout is the raw carry.
  - Subtraction is computed as a + ~b + ~cin.
  - ovf is evaluated on signed interpretation.
- Boundary conditions:
  - Carry propagates across every digit boundary.
  - Operand values at the extremes (all 0s, all 1s, 0x8000-style) require no special casing.
- Reset mid-operation: asynchronous assertion in RUN or DONE aborts immediately. Any pending result is discarded and outputs return to reset values. The first edge after release can accept new operands.

Test Plan:
- Add, WIDTH=16, DIGIT=4: a=0x1234, b=0x4321, cin=0, sub=0 -> s=0x5555, cout=0, ovf=0; out_valid rises exactly 4 edges after accept.
- Carry chain: a=0xFFFF, b=0x0001, cin=0 -> s=0x0000, cout=1, ovf=0. Then a=0x7FFF, b=0x0001 -> s=0x8000, cout=0, ovf=1.
- Subtract:
  - a=0x0005, b=0x0007, cin=0, sub=1 -> s=0xFFFE, cout=0 (borrow), ovf=0.
  - a=0x8000, b=0x0001 -> s=0x7FFF, cout=1, ovf=1.
  - a=0x0010, b=0x0001, cin=1 -> s=0x000E.
- Backpressure: hold out_ready=0 for 5 cycles in DONE while toggling in_valid and operands -> s/cout/ovf unchanged, in_ready=0, no new accept. Raise out_ready -> out_valid=0 and in_ready=1 next cycle.
- Reset mid-RUN: assert rst 2 cycles after accept -> out_valid=0, s=0, in_ready=0 during reset. After release, accept 0x00FF + 0x0001 -> s=0x0100 with no residue from the aborted op.
- Parameter sweep: DIGIT=1, 8, 16 with WIDTH=16 -> latency 16, 2, 1 cycles respectively. Random operands match a+b+cin / a-b-cin reference model, including cout and ovf.
